// File: rtl/csr_commit_sequencer_pkg.sv
// rtl/csr_commit_sequencer_pkg.sv - shared CSR command type and sequencer state encodings
package csr_commit_sequencer_pkg;

  localparam int CSR_ADDR_SIZE = 12;

  typedef enum logic [2:0] {
    CSR_CMD_NONE  = 3'd0,
    CSR_CMD_READ  = 3'd1,
    CSR_CMD_RW    = 3'd2,
    CSR_CMD_RS    = 3'd3,
    CSR_CMD_RC    = 3'd4,
    CSR_CMD_SYS   = 3'd5
  } csr_cmd_t;

  typedef logic [2:0] csr_seq_state_t;

  localparam csr_seq_state_t SEQ_IDLE  = 3'd0;
  localparam csr_seq_state_t SEQ_DRAIN = 3'd1;
  localparam csr_seq_state_t SEQ_ISSUE = 3'd2;
  localparam csr_seq_state_t SEQ_WAIT  = 3'd3;
  localparam csr_seq_state_t SEQ_WFI   = 3'd4;
  localparam csr_seq_state_t SEQ_DONE  = 3'd5;

endpackage

// File: rtl/csr_commit_sequencer.sv
// rtl/csr_commit_sequencer.sv - serialises system instructions at the commit head into one CSR request
module csr_commit_sequencer
  import csr_commit_sequencer_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int CSR_ADDR_W  = CSR_ADDR_SIZE,
  parameter int WFI_TIMEOUT = 0,
  parameter int PERF_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  cmt_valid_i,
  input  logic                  cmt_is_sys_i,
  input  logic                  cmt_is_wfi_i,
  input  csr_cmd_t              cmt_cmd_i,
  input  logic [CSR_ADDR_W-1:0] cmt_addr_i,
  input  logic [DATA_W-1:0]     cmt_data_i,
  input  logic                  sb_empty_i,
  output logic                  csr_req_valid_o,
  output csr_cmd_t              csr_req_cmd_o,
  output logic [CSR_ADDR_W-1:0] csr_req_addr_o,
  output logic [DATA_W-1:0]     csr_req_data_o,
  input  logic                  csr_resp_valid_i,
  input  logic [DATA_W-1:0]     csr_resp_rdata_i,
  input  logic                  csr_resp_xcpt_i,
  input  logic                  irq_pending_i,
  output logic                  commit_stall_o,
  output logic                  done_o,
  output logic [DATA_W-1:0]     done_rdata_o,
  output logic                  done_xcpt_o,
  output logic                  pipe_flush_o,
  output logic [PERF_W-1:0]     stall_cycles_o
);

  localparam bit          WFI_TW_EN = (WFI_TIMEOUT != 0);
  localparam logic [31:0] WFI_LAST  = 32'(WFI_TIMEOUT - 1);

  csr_seq_state_t        state_q, state_d;
  csr_cmd_t              cmd_q;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]     data_q;
  logic                  is_wfi_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  xcpt_q;
  logic [31:0]           wfi_cnt_q;
  logic [PERF_W-1:0]     stall_cnt_q;

  logic latch_op, take_resp, wfi_inc, wfi_tw;

  always_comb begin
    state_d   = state_q;
    latch_op  = 1'b0;
    take_resp = 1'b0;
    wfi_inc   = 1'b0;
    wfi_tw    = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (cmt_valid_i && cmt_is_sys_i && !flush_i) begin
          latch_op = 1'b1;
          state_d  = sb_empty_i ? SEQ_ISSUE : SEQ_DRAIN;
        end
      end
      SEQ_DRAIN: begin
        if (flush_i)         state_d = SEQ_IDLE;
        else if (sb_empty_i) state_d = SEQ_ISSUE;
      end
      SEQ_ISSUE: begin
        if (flush_i) begin
          state_d = SEQ_IDLE;
        end else if (csr_resp_valid_i) begin
          take_resp = 1'b1;
          state_d   = (is_wfi_q && !csr_resp_xcpt_i) ? SEQ_WFI : SEQ_DONE;
        end else begin
          state_d = SEQ_WAIT;
        end
      end
      // Once the request is out its side effects are real, so flush cannot cancel it here.
      SEQ_WAIT: begin
        if (csr_resp_valid_i) begin
          take_resp = 1'b1;
          state_d   = (is_wfi_q && !csr_resp_xcpt_i) ? SEQ_WFI : SEQ_DONE;
        end
      end
      SEQ_WFI: begin
        if (flush_i) begin
          state_d = SEQ_IDLE;
        end else if (irq_pending_i) begin
          state_d = SEQ_DONE;
        end else if (WFI_TW_EN && (wfi_cnt_q == WFI_LAST)) begin
          wfi_tw  = 1'b1;
          state_d = SEQ_DONE;
        end else begin
          wfi_inc = 1'b1;
        end
      end
      SEQ_DONE: state_d = SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= SEQ_IDLE;
      cmd_q       <= CSR_CMD_NONE;
      addr_q      <= '0;
      data_q      <= '0;
      is_wfi_q    <= 1'b0;
      rdata_q     <= '0;
      xcpt_q      <= 1'b0;
      wfi_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_op) begin
        cmd_q    <= cmt_cmd_i;
        addr_q   <= cmt_addr_i;
        data_q   <= cmt_data_i;
        is_wfi_q <= cmt_is_wfi_i;
      end
      if (take_resp) begin
        rdata_q   <= csr_resp_rdata_i;
        xcpt_q    <= csr_resp_xcpt_i;
        wfi_cnt_q <= '0;
      end else if (wfi_inc) begin
        wfi_cnt_q <= wfi_cnt_q + 32'd1;
      end
      if (wfi_tw) xcpt_q <= 1'b1;
      if (commit_stall_o && (stall_cnt_q != {PERF_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign csr_req_valid_o = (state_q == SEQ_ISSUE) && !flush_i;
  assign csr_req_cmd_o   = cmd_q;
  assign csr_req_addr_o  = addr_q;
  assign csr_req_data_o  = data_q;

  assign commit_stall_o = ((state_q == SEQ_IDLE) && cmt_valid_i && cmt_is_sys_i) ||
                          (state_q == SEQ_DRAIN) || (state_q == SEQ_ISSUE) ||
                          (state_q == SEQ_WAIT)  || (state_q == SEQ_WFI);

  assign done_o         = (state_q == SEQ_DONE);
  assign done_rdata_o   = rdata_q;
  assign done_xcpt_o    = done_o && xcpt_q;
  assign pipe_flush_o   = done_o && !xcpt_q && (cmd_q != CSR_CMD_READ);
  assign stall_cycles_o = stall_cnt_q;

  a_resp_in_window: assert property (@(posedge clk_i) disable iff (!rstn_i)
    csr_resp_valid_i |-> ((state_q == SEQ_ISSUE) || (state_q == SEQ_WAIT)));

endmodule

// File: tb/tb_csr_commit_sequencer.sv
// tb/tb_csr_commit_sequencer.sv - scoreboard bench for csr_commit_sequencer
module tb_csr_commit_sequencer;
  import csr_commit_sequencer_pkg::*;

  localparam int DW = 64;
  localparam int AW = 12;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush, cmt_valid, cmt_is_sys, cmt_is_wfi;
  csr_cmd_t      cmt_cmd;
  logic [AW-1:0] cmt_addr;
  logic [DW-1:0] cmt_data;
  logic          sb_empty;
  logic          req_valid;
  csr_cmd_t      req_cmd;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_xcpt;
  logic          irq;
  logic          commit_stall, done, done_xcpt, pipe_flush;
  logic [DW-1:0] done_rdata;
  logic [PW-1:0] stall_cycles;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          xcpt;
    logic          flush;
  } exp_t;

  exp_t          sb_q[$];
  int            total = 0;
  int            bad   = 0;
  logic [PW-1:0] exp_stall = '0;

  csr_commit_sequencer #(.DATA_W(DW), .CSR_ADDR_W(AW), .WFI_TIMEOUT(8), .PERF_W(PW)) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
    .cmt_valid_i(cmt_valid), .cmt_is_sys_i(cmt_is_sys), .cmt_is_wfi_i(cmt_is_wfi),
    .cmt_cmd_i(cmt_cmd), .cmt_addr_i(cmt_addr), .cmt_data_i(cmt_data),
    .sb_empty_i(sb_empty),
    .csr_req_valid_o(req_valid), .csr_req_cmd_o(req_cmd),
    .csr_req_addr_o(req_addr), .csr_req_data_o(req_data),
    .csr_resp_valid_i(resp_valid), .csr_resp_rdata_i(resp_rdata), .csr_resp_xcpt_i(resp_xcpt),
    .irq_pending_i(irq), .commit_stall_o(commit_stall),
    .done_o(done), .done_rdata_o(done_rdata), .done_xcpt_o(done_xcpt),
    .pipe_flush_o(pipe_flush), .stall_cycles_o(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [PW-1:0] sat_add(input logic [PW-1:0] a, input int n);
    int s;
    s = int'(a) + n;
    if (s > (1 << PW) - 1) return '1;
    return s[PW-1:0];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input csr_cmd_t c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic wfi, input logic sbe);
    cmt_valid  = 1'b1;
    cmt_is_sys = 1'b1;
    cmt_is_wfi = wfi;
    cmt_cmd    = c;
    cmt_addr   = a;
    cmt_data   = d;
    sb_empty   = sbe;
  endtask

  task automatic clear_cmt();
    cmt_valid  = 1'b0;
    cmt_is_sys = 1'b0;
    cmt_is_wfi = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    flush = 0; irq = 0; resp_valid = 0; resp_rdata = '0; resp_xcpt = 0;
    clear_cmt(); cmt_cmd = CSR_CMD_NONE; cmt_addr = '0; cmt_data = '0; sb_empty = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if ({req_valid, req_cmd, req_addr, req_data, commit_stall, done, done_rdata, done_xcpt,
         pipe_flush, stall_cycles} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got stall=%b done=%b req=%b cnt=%0d want all zero",
               commit_stall, done, req_valid, stall_cycles);
    end
    next_cycle();
    rstn = 1'b1;
    next_cycle();
  endtask

  task automatic test_rw_fast();
    exp_t e;
    start_op(CSR_CMD_RW, 12'h300, 64'hA, 1'b0, 1'b1);
    sb_q.push_back('{64'h1800, 1'b0, 1'b1});
    @(negedge clk);
    total++;
    if ({commit_stall, req_valid} !== 2'b10) begin
      bad++; $display("FAIL rw_accept: got stall=%b req=%b want 1 0", commit_stall, req_valid);
    end
    next_cycle();
    clear_cmt(); resp_valid = 1'b1; resp_rdata = 64'h1800;
    @(negedge clk);
    total++;
    if ({req_valid, req_cmd, req_addr, req_data, done} !== {1'b1, CSR_CMD_RW, 12'h300, 64'hA, 1'b0}) begin
      bad++; $display("FAIL rw_req: got v=%b cmd=%0d addr=%h data=%h done=%b want 1 %0d 300 a 0",
                      req_valid, req_cmd, req_addr, req_data, done, CSR_CMD_RW);
    end
    next_cycle();
    resp_valid = 1'b0; resp_rdata = '0;
    @(negedge clk);
    e = sb_q.pop_front();
    total++;
    if ({done, commit_stall, done_rdata, done_xcpt, pipe_flush} !== {1'b1, 1'b0, e.rdata, e.xcpt, e.flush}) begin
      bad++; $display("FAIL rw_done: got done=%b stall=%b rdata=%h x=%b pf=%b want 1 0 %h %b %b",
                      done, commit_stall, done_rdata, done_xcpt, pipe_flush, e.rdata, e.xcpt, e.flush);
    end
    exp_stall = sat_add(exp_stall, 2);
    next_cycle();
    @(negedge clk);
    total++;
    if ({done, stall_cycles} !== {1'b0, exp_stall}) begin
      bad++; $display("FAIL rw_after: got done=%b cnt=%0d want 0 %0d", done, stall_cycles, exp_stall);
    end
    next_cycle();
  endtask

  task automatic test_drain_read();
    exp_t e;
    bit   seen;
    start_op(CSR_CMD_READ, 12'hC00, '0, 1'b0, 1'b0);
    sb_q.push_back('{64'hDEAD, 1'b0, 1'b0});
    next_cycle();
    clear_cmt();
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) sb_empty = 1'b1;
      @(negedge clk);
      total++;
      if ({req_valid, commit_stall} !== 2'b01) begin
        bad++; $display("FAIL drain_hold_%0d: got req=%b stall=%b want 0 1", i, req_valid, commit_stall);
      end
      next_cycle();
    end
    resp_valid = 1'b1; resp_rdata = 64'hDEAD;
    @(negedge clk);
    total++;
    if ({req_valid, req_cmd, req_addr} !== {1'b1, CSR_CMD_READ, 12'hC00}) begin
      bad++; $display("FAIL drain_req: got v=%b cmd=%0d addr=%h want 1 %0d c00", req_valid, req_cmd, req_addr, CSR_CMD_READ);
    end
    next_cycle();
    resp_valid = 1'b0; resp_rdata = '0;
    wait_done(1, seen);
    total++;
    if (!seen) begin
      bad++; $display("FAIL drain_done_timeout: got no done want done");
    end else begin
      e = sb_q.pop_front();
      total++;
      if ({done_rdata, done_xcpt, pipe_flush} !== {e.rdata, e.xcpt, e.flush}) begin
        bad++; $display("FAIL drain_done: got %h %b %b want %h %b %b", done_rdata, done_xcpt, pipe_flush, e.rdata, e.xcpt, e.flush);
      end
    end
    exp_stall = sat_add(exp_stall, 7);
    next_cycle();
    @(negedge clk);
    total++;
    if (stall_cycles !== exp_stall) begin
      bad++; $display("FAIL drain_stall_count: got %0d want %0d", stall_cycles, exp_stall);
    end
    next_cycle();
  endtask

  task automatic test_flush_drain();
    start_op(CSR_CMD_RW, 12'h340, 64'h5, 1'b0, 1'b0);
    next_cycle();
    clear_cmt(); flush = 1'b1;
    @(negedge clk);
    total++;
    if ({commit_stall, req_valid} !== 2'b10) begin
      bad++; $display("FAIL flush_in_drain: got stall=%b req=%b want 1 0", commit_stall, req_valid);
    end
    next_cycle();
    flush = 1'b0; sb_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({req_valid, done, commit_stall} !== 3'b000) begin
        bad++; $display("FAIL flush_idle_%0d: got req=%b done=%b stall=%b want 0 0 0", i, req_valid, done, commit_stall);
      end
      next_cycle();
    end
    exp_stall = sat_add(exp_stall, 2);
    @(negedge clk);
    total++;
    if (stall_cycles !== exp_stall) begin
      bad++; $display("FAIL flush_stall_count: got %0d want %0d", stall_cycles, exp_stall);
    end
    next_cycle();
  endtask

  task automatic test_wfi_timeout();
    exp_t e;
    bit   seen;
    start_op(CSR_CMD_SYS, '0, '0, 1'b1, 1'b1);
    sb_q.push_back('{64'h0, 1'b1, 1'b0});
    next_cycle();
    clear_cmt(); resp_valid = 1'b1; resp_rdata = '0;
    @(negedge clk);
    total++;
    if (req_valid !== 1'b1) begin
      bad++; $display("FAIL wfi_req: got %b want 1", req_valid);
    end
    next_cycle();
    resp_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if ({done, commit_stall} !== 2'b01) begin
        bad++; $display("FAIL wfi_wait_%0d: got done=%b stall=%b want 0 1", i, done, commit_stall);
      end
      next_cycle();
    end
    wait_done(1, seen);
    total++;
    if (!seen) begin
      bad++; $display("FAIL wfi_tw_timeout: got no done want done");
    end else begin
      e = sb_q.pop_front();
      total++;
      if ({done_rdata, done_xcpt, pipe_flush} !== {e.rdata, e.xcpt, e.flush}) begin
        bad++; $display("FAIL wfi_tw_done: got %h %b %b want %h %b %b", done_rdata, done_xcpt, pipe_flush, e.rdata, e.xcpt, e.flush);
      end
    end
    exp_stall = sat_add(exp_stall, 10);
    next_cycle();
    @(negedge clk);
    total++;
    if (stall_cycles !== exp_stall) begin
      bad++; $display("FAIL wfi_tw_stall_count: got %0d want %0d", stall_cycles, exp_stall);
    end
    next_cycle();
  endtask

  task automatic test_wfi_irq();
    exp_t e;
    bit   seen;
    start_op(CSR_CMD_SYS, '0, '0, 1'b1, 1'b1);
    sb_q.push_back('{64'h55, 1'b0, 1'b1});
    next_cycle();
    clear_cmt();
    next_cycle();
    resp_valid = 1'b1; resp_rdata = 64'h55;
    next_cycle();
    resp_valid = 1'b0; resp_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) irq = 1'b1;
      @(negedge clk);
      total++;
      if ({done, commit_stall} !== 2'b01) begin
        bad++; $display("FAIL wfi_irq_wait_%0d: got done=%b stall=%b want 0 1", i, done, commit_stall);
      end
      next_cycle();
    end
    irq = 1'b0;
    wait_done(1, seen);
    total++;
    if (!seen) begin
      bad++; $display("FAIL wfi_irq_timeout: got no done want done");
    end else begin
      e = sb_q.pop_front();
      total++;
      if ({done_rdata, done_xcpt, pipe_flush} !== {e.rdata, e.xcpt, e.flush}) begin
        bad++; $display("FAIL wfi_irq_done: got %h %b %b want %h %b %b", done_rdata, done_xcpt, pipe_flush, e.rdata, e.xcpt, e.flush);
      end
    end
    exp_stall = sat_add(exp_stall, 7);
    next_cycle();
    @(negedge clk);
    total++;
    if (stall_cycles !== exp_stall) begin
      bad++; $display("FAIL wfi_irq_stall_count: got %0d want %0d", stall_cycles, exp_stall);
    end
    next_cycle();
  endtask

  task automatic test_csr_xcpt();
    exp_t e;
    bit   seen;
    start_op(CSR_CMD_RS, 12'h7C0, 64'hF0, 1'b0, 1'b1);
    sb_q.push_back('{64'h1234, 1'b1, 1'b0});
    next_cycle();
    clear_cmt();
    @(negedge clk);
    total++;
    if ({req_valid, req_cmd, req_addr, req_data} !== {1'b1, CSR_CMD_RS, 12'h7C0, 64'hF0}) begin
      bad++; $display("FAIL rs_req: got v=%b cmd=%0d addr=%h data=%h want 1 %0d 7c0 f0", req_valid, req_cmd, req_addr, req_data, CSR_CMD_RS);
    end
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    total++;
    if ({commit_stall, req_valid} !== 2'b10) begin
      bad++; $display("FAIL wait_ignores_flush: got stall=%b req=%b want 1 0", commit_stall, req_valid);
    end
    next_cycle();
    flush = 1'b0; resp_valid = 1'b1; resp_rdata = 64'h1234; resp_xcpt = 1'b1;
    next_cycle();
    resp_valid = 1'b0; resp_rdata = '0; resp_xcpt = 1'b0;
    wait_done(1, seen);
    total++;
    if (!seen) begin
      bad++; $display("FAIL rs_done_timeout: got no done want done");
    end else begin
      e = sb_q.pop_front();
      total++;
      if ({done_rdata, done_xcpt, pipe_flush} !== {e.rdata, e.xcpt, e.flush}) begin
        bad++; $display("FAIL rs_xcpt_done: got %h %b %b want %h %b %b", done_rdata, done_xcpt, pipe_flush, e.rdata, e.xcpt, e.flush);
      end
    end
    exp_stall = sat_add(exp_stall, 4);
    next_cycle();
    @(negedge clk);
    total++;
    if (stall_cycles !== exp_stall) begin
      bad++; $display("FAIL rs_stall_saturate: got %0d want %0d", stall_cycles, exp_stall);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    start_op(CSR_CMD_RW, 12'h305, 64'h11, 1'b0, 1'b1);
    sb_q.push_back('{64'hA1, 1'b0, 1'b1});
    next_cycle();
    clear_cmt(); resp_valid = 1'b1; resp_rdata = 64'hA1;
    next_cycle();
    resp_valid = 1'b0; resp_rdata = '0;
    start_op(CSR_CMD_READ, 12'h306, '0, 1'b0, 1'b1);
    @(negedge clk);
    e = sb_q.pop_front();
    total++;
    if ({done, commit_stall, done_rdata, pipe_flush} !== {1'b1, 1'b0, e.rdata, e.flush}) begin
      bad++; $display("FAIL b2b_first_done: got done=%b stall=%b rdata=%h pf=%b want 1 0 %h %b", done, commit_stall, done_rdata, pipe_flush, e.rdata, e.flush);
    end
    sb_q.push_back('{64'hB2, 1'b0, 1'b0});
    next_cycle();
    @(negedge clk);
    total++;
    if ({commit_stall, done} !== 2'b10) begin
      bad++; $display("FAIL b2b_second_accept: got stall=%b done=%b want 1 0", commit_stall, done);
    end
    next_cycle();
    clear_cmt(); resp_valid = 1'b1; resp_rdata = 64'hB2;
    @(negedge clk);
    total++;
    if ({req_valid, req_cmd, req_addr} !== {1'b1, CSR_CMD_READ, 12'h306}) begin
      bad++; $display("FAIL b2b_second_req: got v=%b cmd=%0d addr=%h want 1 %0d 306", req_valid, req_cmd, req_addr, CSR_CMD_READ);
    end
    next_cycle();
    resp_valid = 1'b0; resp_rdata = '0;
    @(negedge clk);
    e = sb_q.pop_front();
    total++;
    if ({done, done_rdata, done_xcpt, pipe_flush} !== {1'b1, e.rdata, e.xcpt, e.flush}) begin
      bad++; $display("FAIL b2b_second_done: got done=%b %h %b %b want 1 %h %b %b", done, done_rdata, done_xcpt, pipe_flush, e.rdata, e.xcpt, e.flush);
    end
    exp_stall = sat_add(exp_stall, 4);
    next_cycle();
    @(negedge clk);
    total++;
    if (stall_cycles !== exp_stall) begin
      bad++; $display("FAIL b2b_stall_no_wrap: got %0d want %0d", stall_cycles, exp_stall);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    start_op(CSR_CMD_RW, 12'h300, 64'h1, 1'b0, 1'b1);
    next_cycle();
    clear_cmt();
    next_cycle();
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({req_valid, req_cmd, req_addr, req_data, commit_stall, done, done_rdata, done_xcpt,
         pipe_flush, stall_cycles} !== '0) begin
      bad++; $display("FAIL reset_mid_wait: got stall=%b req=%b addr=%h cnt=%0d want all zero",
                      commit_stall, req_valid, req_addr, stall_cycles);
    end
    exp_stall = '0;
    next_cycle();
    rstn = 1'b1;
    start_op(CSR_CMD_RC, 12'h301, 64'h2, 1'b0, 1'b1);
    sb_q.push_back('{64'h77, 1'b0, 1'b1});
    @(negedge clk);
    total++;
    if ({commit_stall, req_valid} !== 2'b10) begin
      bad++; $display("FAIL post_reset_accept: got stall=%b req=%b want 1 0", commit_stall, req_valid);
    end
    next_cycle();
    clear_cmt(); resp_valid = 1'b1; resp_rdata = 64'h77;
    @(negedge clk);
    total++;
    if ({req_valid, req_cmd} !== {1'b1, CSR_CMD_RC}) begin
      bad++; $display("FAIL post_reset_req: got v=%b cmd=%0d want 1 %0d", req_valid, req_cmd, CSR_CMD_RC);
    end
    next_cycle();
    resp_valid = 1'b0; resp_rdata = '0;
    @(negedge clk);
    e = sb_q.pop_front();
    total++;
    if ({done, done_rdata, done_xcpt, pipe_flush} !== {1'b1, e.rdata, e.xcpt, e.flush}) begin
      bad++; $display("FAIL post_reset_done: got done=%b %h %b %b want 1 %h %b %b", done, done_rdata, done_xcpt, pipe_flush, e.rdata, e.xcpt, e.flush);
    end
    exp_stall = sat_add(exp_stall, 2);
    next_cycle();
    @(negedge clk);
    total++;
    if (stall_cycles !== exp_stall) begin
      bad++; $display("FAIL post_reset_stall_count: got %0d want %0d", stall_cycles, exp_stall);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_rw_fast();
    test_drain_read();
    test_flush_drain();
    test_wfi_timeout();
    test_wfi_irq();
    test_csr_xcpt();
    test_back_to_back();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
